data_sram_responder: RTL and testbench

- Target-side responder for the CPU's data SRAM interface (en / we / addr / wdata / rdata). Serves every load and store the pipeline's MEM stage issues.
- Contains a word-organised data RAM with byte write enables.
- Contains a small MMIO register window: LED output, synchronised switch input, and a free-running timer with compare-match interrupt.
- Instantiated next to the CPU top in the SoC wrapper. Its rdata feeds the WB-stage load path and bypass.

---
 rtl/data_sram_responder.sv | 128 ++++++++++++
 tb/tb_data_sram_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Data-side SRAM target for the CPU: word RAM with byte enables plus an LED/switch/timer MMIO window.
// Read data is registered with 1-cycle latency and stores are read-first; there is no backpressure.
module data_sram_responder #(
    parameter int          ADDR_W    = 14,
    parameter logic [31:0] MMIO_BASE = 32'hbfaf_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch,
    output logic        timer_irq
);

    localparam logic [13:0] OFF_LED   = 14'd0;
    localparam logic [13:0] OFF_SW    = 14'd1;
    localparam logic [13:0] OFF_TIMER = 14'd2;
    localparam logic [13:0] OFF_TCMP  = 14'd3;
    localparam logic [13:0] OFF_CTRL  = 14'd4;

    logic [31:0]       r_mem [0:(2**ADDR_W)-1];
    logic [31:0]       r_rdata;
    logic [15:0]       r_led;
    logic [7:0]        r_sw_meta;
    logic [7:0]        r_sw_sync;
    logic [31:0]       r_timer;
    logic [31:0]       r_tcmp;
    logic              r_ctrl_en;
    logic              r_pend;

    logic              w_is_mmio;
    logic [13:0]       w_off;
    logic [ADDR_W-1:0] w_idx;
    logic              w_mmio_wr;
    logic              w_ram_wr;
    logic              w_tmatch;
    logic [31:0]       w_mmio_rd;
    logic              w_unused;

    assign w_is_mmio = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
    assign w_off     = data_sram_addr[15:2];
    assign w_idx     = data_sram_addr[ADDR_W+1:2];
    assign w_mmio_wr = data_sram_en & w_is_mmio & (data_sram_we == 4'hf);
    assign w_ram_wr  = data_sram_en & ~w_is_mmio & (data_sram_we != 4'h0);
    // Compare uses pre-edge timer value so a match is seen exactly once per pass.
    assign w_tmatch  = r_ctrl_en & (r_timer == r_tcmp);
    assign w_unused  = &{1'b0, data_sram_addr};

    always_comb begin
        w_mmio_rd = 32'h0;
        case (w_off)
            OFF_LED:   w_mmio_rd = {16'h0, r_led};
            OFF_SW:    w_mmio_rd = {24'h0, r_sw_sync};
            OFF_TIMER: w_mmio_rd = r_timer;
            OFF_TCMP:  w_mmio_rd = r_tcmp;
            OFF_CTRL:  w_mmio_rd = {30'h0, r_pend, r_ctrl_en};
            default:   w_mmio_rd = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) begin
                    r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'h0;
        end else if (data_sram_en) begin
            r_rdata <= w_is_mmio ? w_mmio_rd : r_mem[w_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_meta <= 8'h0;
            r_sw_sync <= 8'h0;
        end else begin
            r_sw_meta <= switch;
            r_sw_sync <= r_sw_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led     <= 16'h0;
            r_timer   <= 32'h0;
            r_tcmp    <= 32'hffff_ffff;
            r_ctrl_en <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            if (w_mmio_wr && w_off == OFF_LED) begin
                r_led <= data_sram_wdata[15:0];
            end
            if (w_mmio_wr && w_off == OFF_TCMP) begin
                r_tcmp <= data_sram_wdata;
            end
            if (w_mmio_wr && w_off == OFF_CTRL) begin
                r_ctrl_en <= data_sram_wdata[0];
            end
            if (w_mmio_wr && w_off == OFF_TIMER) begin
                r_timer <= data_sram_wdata;
            end else if (r_ctrl_en) begin
                r_timer <= r_timer + 32'd1;
            end
            // A new match outranks a simultaneous W1C so no interrupt is lost.
            if (w_tmatch) begin
                r_pend <= 1'b1;
            end else if (w_mmio_wr && w_off == OFF_CTRL && data_sram_wdata[1]) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign data_sram_rdata = r_rdata;
    assign led             = r_led;
    assign timer_irq       = r_pend;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomised scoreboard bench for data_sram_responder against a behavioural model.
module tb_data_sram_responder;

    localparam logic [31:0] MMIO_BASE = 32'hbfaf_0000;
    localparam logic [15:0] MB        = 16'hbfaf;

    typedef struct {
        logic        rd_known;
        logic [31:0] rd;
        logic [15:0] led;
        logic        irq;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [15:0] led;
    logic [7:0]  switch;
    logic        timer_irq;

    int n_vec;
    int n_err;
    exp_t exp_q[$];

    // Behavioural model state
    logic [31:0] m_ram [int];
    logic [31:0] m_rd;
    logic        m_rd_known;
    logic [15:0] m_led;
    logic [31:0] m_timer;
    logic [31:0] m_tcmp;
    logic        m_cen;
    logic        m_pend;
    logic [7:0]  m_sw_hist[$];

    data_sram_responder #(.ADDR_W(14), .MMIO_BASE(MMIO_BASE)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .led             (led),
        .switch          (switch),
        .timer_irq       (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_rd = 32'h0;
        m_rd_known = 1'b1;
        m_led = 16'h0;
        m_timer = 32'h0;
        m_tcmp = 32'hffff_ffff;
        m_cen = 1'b0;
        m_pend = 1'b0;
        m_sw_hist = '{8'h0, 8'h0};
    endtask

    // Called at a negedge: drive one access, predict the state after the next posedge.
    task automatic tick(input logic en, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        logic mmio, full, hit;
        logic [15:0] off;
        logic [31:0] rv, nw;
        logic [7:0] sw_vis;
        int idx;
        data_sram_en = en;
        data_sram_we = we;
        data_sram_addr = addr;
        data_sram_wdata = wd;
        mmio = (addr[31:16] == MB);
        off = {addr[15:2], 2'b00};
        idx = int'(addr[15:2]);
        sw_vis = m_sw_hist[0];
        rv = 32'h0;
        hit = 1'b1;
        if (mmio) begin
            if (off == 16'h0000) rv = {16'h0, m_led};
            else if (off == 16'h0004) rv = {24'h0, sw_vis};
            else if (off == 16'h0008) rv = m_timer;
            else if (off == 16'h000c) rv = m_tcmp;
            else if (off == 16'h0010) rv = {30'h0, m_pend, m_cen};
        end else if (m_ram.exists(idx)) begin
            rv = m_ram[idx];
        end else begin
            hit = 1'b0;
        end
        if (en) begin
            m_rd = rv;
            m_rd_known = hit;
        end
        if (en && !mmio && we != 4'h0) begin
            nw = m_ram.exists(idx) ? m_ram[idx] : 32'h0;
            for (int b = 0; b < 4; b++) if (we[b]) nw[8*b +: 8] = wd[8*b +: 8];
            m_ram[idx] = nw;
        end
        full = en && mmio && we == 4'hf;
        begin
            logic set_now;
            set_now = m_cen && (m_timer == m_tcmp);
            if (full && off == 16'h0008) m_timer = wd;
            else if (m_cen) m_timer = m_timer + 32'd1;
            if (set_now) m_pend = 1'b1;
            else if (full && off == 16'h0010 && wd[1]) m_pend = 1'b0;
        end
        if (full && off == 16'h0000) m_led = wd[15:0];
        if (full && off == 16'h000c) m_tcmp = wd;
        if (full && off == 16'h0010) m_cen = wd[0];
        m_sw_hist.push_back(switch);
        void'(m_sw_hist.pop_front());
        e.rd_known = m_rd_known;
        e.rd = m_rd;
        e.led = m_led;
        e.irq = m_pend;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Monitor: pops one prediction per edge that the driver announced.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.rd_known) check("rdata", data_sram_rdata, e.rd);
                check("led", {16'h0, led}, {16'h0, e.led});
                check("timer_irq", {31'h0, timer_irq}, {31'h0, e.irq});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  r_we;
        logic [31:0] r_addr, r_wd;
        logic [15:0] ups [3];
        logic [15:0] offs [7];
        n_vec = 0;
        n_err = 0;
        ups = '{16'h0000, 16'h0001, 16'h1234};
        offs = '{16'h0000, 16'h0004, 16'h0008, 16'h000c, 16'h0010, 16'h0014, 16'h0020};
        rst = 1'b1;
        switch = 8'h00;
        data_sram_en = 1'b0;
        data_sram_we = 4'h0;
        data_sram_addr = 32'h0;
        data_sram_wdata = 32'h0;
        model_reset();
        #1;
        check("reset_rdata", data_sram_rdata, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);
        check("reset_irq", {31'h0, timer_irq}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset values visible through MMIO reads
        tick(1'b1, 4'h0, MMIO_BASE + 32'h8, 32'h0);
        tick(1'b1, 4'h0, MMIO_BASE + 32'hc, 32'h0);
        tick(1'b1, 4'h0, MMIO_BASE + 32'h10, 32'h0);

        // Word store/load, hold, byte-enable merge, aliasing
        tick(1'b1, 4'hf, 32'h0000_0100, 32'h1234_5678);
        tick(1'b1, 4'h0, 32'h0000_0100, 32'h0);
        idle(2);
        tick(1'b1, 4'b0101, 32'h0000_0100, 32'haabb_ccdd);
        tick(1'b1, 4'h0, 32'h0000_0100, 32'h0);
        tick(1'b1, 4'h0, 32'h0001_0100, 32'h0);
        tick(1'b1, 4'hf, 32'h0000_0200, 32'hcafe_f00d);

        // LED, partial MMIO write ignored, unmapped offset
        tick(1'b1, 4'hf, MMIO_BASE, 32'h0000_a5a5);
        tick(1'b1, 4'b0001, MMIO_BASE, 32'h0000_00ff);
        tick(1'b1, 4'h0, MMIO_BASE + 32'h20, 32'h0);
        tick(1'b1, 4'h0, MMIO_BASE, 32'h0);

        // Switch synchroniser delay
        switch = 8'h3c;
        tick(1'b1, 4'h0, MMIO_BASE + 32'h4, 32'h0);
        tick(1'b1, 4'h0, MMIO_BASE + 32'h4, 32'h0);
        tick(1'b1, 4'h0, MMIO_BASE + 32'h4, 32'h0);

        // Timer compare, W1C in non-match, W1C losing to a match
        tick(1'b1, 4'hf, MMIO_BASE + 32'hc, 32'd5);
        tick(1'b1, 4'hf, MMIO_BASE + 32'h8, 32'd0);
        tick(1'b1, 4'hf, MMIO_BASE + 32'h10, 32'd1);
        for (int i = 0; i < 8; i++) tick(1'b1, 4'h0, MMIO_BASE + 32'h8, 32'h0);
        tick(1'b1, 4'hf, MMIO_BASE + 32'h10, 32'd3);
        idle(1);
        tick(1'b1, 4'hf, MMIO_BASE + 32'h8, 32'd4);
        idle(1);
        tick(1'b1, 4'hf, MMIO_BASE + 32'h10, 32'd3);
        idle(1);

        // Reset with a load outstanding and the timer running
        tick(1'b1, 4'h0, 32'h0000_0200, 32'h0);
        rst = 1'b1;
        data_sram_en = 1'b1;
        data_sram_we = 4'h0;
        data_sram_addr = 32'h0000_0100;
        #1;
        check("midrst_rdata", data_sram_rdata, 32'h0);
        check("midrst_led", {16'h0, led}, 32'h0);
        check("midrst_irq", {31'h0, timer_irq}, 32'h0);
        model_reset();
        begin
            exp_t e;
            e.rd_known = 1'b1; e.rd = 32'h0; e.led = 16'h0; e.irq = 1'b0;
            exp_q.push_back(e);
        end
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, 4'h0, MMIO_BASE + 32'h8, 32'h0);
        tick(1'b1, 4'h0, MMIO_BASE + 32'hc, 32'h0);
        tick(1'b1, 4'h0, 32'h0000_0200, 32'h0);
        tick(1'b1, 4'h0, MMIO_BASE + 32'h4, 32'h0);
        tick(1'b1, 4'h0, MMIO_BASE + 32'h4, 32'h0);

        // Fill the random RAM pool so every later load has a known answer
        for (int i = 0; i < 16; i++) tick(1'b1, 4'hf, {16'h0, 10'h0, i[3:0], 2'b00}, $urandom);

        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 15) == 0) switch = 8'($urandom);
            case ($urandom_range(0, 3))
                0: r_we = 4'h0;
                1: r_we = 4'hf;
                default: r_we = 4'($urandom);
            endcase
            r_wd = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 12)) : $urandom;
            if ($urandom_range(0, 9) < 6)
                r_addr = {ups[$urandom_range(0, 2)], 10'h0, 4'($urandom), 2'($urandom)};
            else
                r_addr = {MB, offs[$urandom_range(0, 6)] | 16'($urandom_range(0, 3))};
            tick($urandom_range(0, 3) != 0, r_we, r_addr, r_wd);
        end

        idle(2);
        @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
